z80_io_initiator: RTL and testbench

Wishbone-controlled Z80 I/O bus initiator: software loads a port address and data byte, then issues a command, and the block plays a Z80 IN or OUT cycle on the external bus with programmable setup, strobe and hold lengths. It is the host-side counterpart of our Z80 mailbox peripheral, so the ASIC can drive a Z80 I/O peripheral (or a second mailbox instance in loopback) directly. It sits on the user-area Wishbone bus beside the mailbox and raises `irq_out` when each bus cycle completes.

---
 rtl/z80_io_initiator.sv | 116 +++++++++++
 tb/tb_z80_io_initiator.sv | 138 +++++++++++++
 2 files changed

// File: rtl/z80_io_initiator.sv
// z80_io_initiator: Wishbone-programmed Z80 IN/OUT bus cycle generator with programmable setup/strobe/hold.
module z80_io_initiator #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100,
  parameter int SETUP_CYCLES = 2,
  parameter int STROBE_CYCLES = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        wb_ack_out,
  output logic [31:0] wb_data_out,
  output logic        z80_ioreq_b,
  output logic        z80_read_strobe_b,
  output logic        z80_write_strobe_b,
  output logic        z80_m1,
  output logic [7:0]  z80_address_bus,
  output logic [7:0]  z80_data_bus_out,
  output logic        z80_data_oe,
  input  logic [7:0]  z80_data_bus_in,
  output logic        irq_out
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state;
  logic [7:0] port_q, data_q, result_q, din_q, cnt;
  logic done, overrun, dir_out, busy, last, access, cmd_wr;
  logic hit_port, hit_data, hit_cmd, hit_stat;
  logic [31:0] rdata;
  logic unused_bits;
  assign unused_bits = ^wb_data_in[31:8];
  assign hit_port = wb_addr_in == BASE_ADDRESS;
  assign hit_data = wb_addr_in == BASE_ADDRESS + 32'd4;
  assign hit_cmd  = wb_addr_in == BASE_ADDRESS + 32'd8;
  assign hit_stat = wb_addr_in == BASE_ADDRESS + 32'd12;
  assign busy = state != IDLE;
  assign last = cnt == 8'd1;
  // One ack per strobe: a held stb is not re-accepted while ack is high.
  assign access = wb_cyc_in & wb_stb_in & ~wb_ack_out & (hit_port | hit_data | hit_cmd | hit_stat);
  assign cmd_wr = access & wb_we_in & hit_cmd;
  always_comb
    rdata = hit_port ? {24'b0, port_q} :
            hit_data ? {24'b0, result_q} :
            hit_stat ? {29'b0, overrun, done, busy} : 32'b0;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      cnt <= 8'd0;
      port_q <= 8'd0;
      data_q <= 8'd0;
      result_q <= 8'd0;
      din_q <= 8'd0;
      done <= 1'b0;
      overrun <= 1'b0;
      dir_out <= 1'b0;
      wb_ack_out <= 1'b0;
      wb_data_out <= 32'd0;
      z80_ioreq_b <= 1'b1;
      z80_read_strobe_b <= 1'b1;
      z80_write_strobe_b <= 1'b1;
      z80_m1 <= 1'b1;
      z80_address_bus <= 8'd0;
      z80_data_bus_out <= 8'd0;
      z80_data_oe <= 1'b0;
      irq_out <= 1'b0;
    end else begin
      wb_ack_out <= access;
      irq_out <= 1'b0;
      z80_m1 <= 1'b1;
      din_q <= z80_data_bus_in;
      if (access) wb_data_out <= rdata;
      if (access && wb_we_in && hit_port) port_q <= wb_data_in[7:0];
      if (access && wb_we_in && hit_data) data_q <= wb_data_in[7:0];
      if (cmd_wr && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (cmd_wr) begin
          dir_out <= wb_data_in[0];
          z80_address_bus <= port_q;
          done <= 1'b0;
          overrun <= 1'b0;
          state <= SETUP;
          cnt <= 8'(SETUP_CYCLES);
          if (wb_data_in[0]) begin
            z80_data_bus_out <= data_q;
            z80_data_oe <= 1'b1;
          end
        end
        SETUP: if (last) begin
          state <= STROBE;
          cnt <= 8'(STROBE_CYCLES);
          z80_ioreq_b <= 1'b0;
          z80_read_strobe_b <= dir_out;
          z80_write_strobe_b <= ~dir_out;
        end else cnt <= cnt - 8'd1;
        STROBE: if (last) begin
          state <= HOLD;
          cnt <= 8'(HOLD_CYCLES);
          z80_ioreq_b <= 1'b1;
          z80_read_strobe_b <= 1'b1;
          z80_write_strobe_b <= 1'b1;
          if (!dir_out) result_q <= din_q;
        end else cnt <= cnt - 8'd1;
        HOLD: if (last) begin
          state <= IDLE;
          z80_data_oe <= 1'b0;
          done <= 1'b1;
          irq_out <= 1'b1;
        end else cnt <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_z80_io_initiator.sv
// tb_z80_io_initiator: randomized IN/OUT transactions checked cycle by cycle against timing windows derived from the setup/strobe/hold lengths.
module tb_z80_io_initiator;
  localparam logic [31:0] B = 32'h3000_0100;
  localparam int S = 2, T = 8, H = 2;
  logic clk = 0, reset_b = 0;
  logic wb_cyc_in = 0, wb_stb_in = 0, wb_we_in = 0;
  logic [31:0] wb_addr_in = 0, wb_data_in = 0;
  logic wb_ack_out;
  logic [31:0] wb_data_out;
  logic z80_ioreq_b, z80_read_strobe_b, z80_write_strobe_b, z80_m1, z80_data_oe, irq_out;
  logic [7:0] z80_address_bus, z80_data_bus_out;
  logic [7:0] z80_data_bus_in = 0;
  int checks = 0, errors = 0;
  int low_cnt = 0, irq_cnt = 0;
  logic [7:0] res_m = 0;
  always #5 clk = ~clk;
  z80_io_initiator #(.BASE_ADDRESS(B), .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset_b(reset_b), .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
    .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in), .wb_ack_out(wb_ack_out), .wb_data_out(wb_data_out),
    .z80_ioreq_b(z80_ioreq_b), .z80_read_strobe_b(z80_read_strobe_b), .z80_write_strobe_b(z80_write_strobe_b),
    .z80_m1(z80_m1), .z80_address_bus(z80_address_bus), .z80_data_bus_out(z80_data_bus_out),
    .z80_data_oe(z80_data_oe), .z80_data_bus_in(z80_data_bus_in), .irq_out(irq_out));
  always @(negedge clk) begin
    if (!z80_ioreq_b) low_cnt <= low_cnt + 1;
    if (irq_out) irq_cnt <= irq_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic wb(input logic we, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r, output logic ok);
    @(negedge clk);
    wb_cyc_in = 1; wb_stb_in = 1; wb_we_in = we; wb_addr_in = a; wb_data_in = d;
    ok = 0; r = 0;
    for (int n = 0; n < 4 && !ok; n++) begin
      @(negedge clk);
      if (wb_ack_out) begin ok = 1; r = wb_data_out; end
    end
    wb_cyc_in = 0; wb_stb_in = 0; wb_we_in = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; logic ok;
    wb(1, a, d, r, ok);
    check("wr_ack", 32'(ok), 1);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] r; logic ok;
    wb(0, a, 0, r, ok);
    check("rd_ack", 32'(ok), 1);
    check(tag, r, exp);
  endtask
  // Full transaction with per-cycle comparison against the ideal waveform.
  task automatic run_cmd(input logic out, input logic [7:0] port, input logic [7:0] data, input logic [7:0] v);
    logic [31:0] r; logic ok; logic low; logic [13:0] exp;
    wr(B, {24'b0, port});
    wr(B + 4, {24'b0, data});
    z80_data_bus_in = 8'($urandom);
    wb(1, B + 8, {31'b0, out}, r, ok);
    check("cmd_ack", 32'(ok), 1);
    for (int k = 0; k <= S + T + H + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (!out && k == S) z80_data_bus_in = v;
      if (!out && k == S + T) z80_data_bus_in = ~v;
      low = k >= S && k < S + T;
      exp = {~low, ~(low & ~out), ~(low & out), out && k < S + T + H, k == S + T + H, 1'b1, port};
      check("bus", {18'b0, z80_ioreq_b, z80_read_strobe_b, z80_write_strobe_b, z80_data_oe, irq_out, z80_m1, z80_address_bus}, {18'b0, exp});
      if (out && k < S + T + H) check("dout", {24'b0, z80_data_bus_out}, {24'b0, data});
    end
    if (!out) res_m = v;
    rd(B + 12, 2, "status_done");
    rd(B + 4, {24'b0, res_m}, "result");
  endtask
  initial begin
    logic [31:0] r; logic ok; int base_low, base_irq;
    #23;
    check("rst_bus", {18'b0, z80_ioreq_b, z80_read_strobe_b, z80_write_strobe_b, z80_data_oe, irq_out, z80_m1, z80_address_bus}, {18'b0, 14'b11100_1_00000000});
    check("rst_wb", {31'b0, wb_ack_out}, 0);
    check("rst_wbd", wb_data_out, 0);
    check("rst_dout", {24'b0, z80_data_bus_out}, 0);
    @(negedge clk); reset_b = 1;
    rd(B + 12, 0, "status_rst");
    rd(B, 0, "port_rst");
    @(negedge clk);
    check("ack_one_cycle", {31'b0, wb_ack_out}, 0);
    wb(0, B + 16, 0, r, ok);
    check("unmapped_rd", 32'(ok), 0);
    wb(1, B + 16, 32'h1, r, ok);
    check("unmapped_wr", 32'(ok), 0);
    check("unmapped_idle", {31'b0, z80_ioreq_b}, 1);
    rd(B + 8, 0, "cmd_read");
    run_cmd(1, 8'h80, 8'hA5, 8'h00);
    run_cmd(0, 8'h81, 8'h00, 8'h3C);
    for (int i = 0; i < 16; i++)
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    // Overrun: second command while busy is acked but starts no bus cycle.
    wr(B, 32'h80); wr(B + 4, 32'hA5);
    base_low = low_cnt; base_irq = irq_cnt;
    wb(1, B + 8, 1, r, ok);
    wr(B + 8, 1);
    wr(B, 32'h11);
    rd(B + 12, 5, "status_overrun_busy");
    for (int n = 0; n < 40 && irq_cnt == base_irq; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("irq_timeout", 32'(irq_cnt - base_irq), 1);
    check("overrun_single", 32'(low_cnt - base_low), T);
    check("addr_hold", {24'b0, z80_address_bus}, 32'h80);
    rd(B + 12, 6, "status_overrun_done");
    rd(B, 32'h11, "port_updated");
    wb(1, B + 8, 1, r, ok);
    rd(B + 12, 1, "status_overrun_clr");
    for (int n = 0; n < 40 && z80_data_oe; n++) @(negedge clk);
    rd(B + 12, 2, "status_after");
    // Asynchronous reset in the middle of the strobe window.
    wr(B + 4, 32'h5A);
    wb(1, B + 8, 1, r, ok);
    repeat (S + 2) @(negedge clk);
    check("mid_strobe", {31'b0, z80_write_strobe_b}, 0);
    #2 reset_b = 0;
    #1;
    check("async_rst", {27'b0, z80_ioreq_b, z80_read_strobe_b, z80_write_strobe_b, z80_data_oe, irq_out}, 32'b11100);
    repeat (3) @(negedge clk);
    check("rst_hold_irq", {31'b0, irq_out}, 0);
    reset_b = 1;
    rd(B + 12, 0, "status_post_rst");
    rd(B + 4, 0, "result_post_rst");
    rd(B, 0, "port_post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
